serial_io_buffer: RTL

SERIAL_IO_BUFFER -- requirements
Module: serial_io_buffer

---
 rtl/serial_io_buffer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_io_buffer.sv
// serial_io_buffer: RX and TX byte FIFOs between a processor port and a UART, plus a TX drain FSM.
// Optional feature: define SERIAL_DROP_COUNT_EN to add the saturating rx_drop_count_out counter.
module serial_io_buffer #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_data_in,
  input  logic       proc_wren_in,
  input  logic       proc_rden_in,
  output logic [7:0] proc_data_out,
  output logic       proc_valid_out,
  output logic       proc_ready_out,
  input  logic [7:0] uart_rx_data_in,
  input  logic       uart_rx_valid_in,
  output logic [7:0] uart_tx_data_out,
  output logic       uart_tx_start_out,
  input  logic       uart_tx_busy_in,
  output logic       rx_overflow_out
`ifdef SERIAL_DROP_COUNT_EN
  ,
  output logic [7:0] rx_drop_count_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_e;

  // RX FIFO: UART -> processor, first-word-fall-through
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;
  logic          rx_ovf_q;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_drop;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CNT_FULL);
  assign rx_pop   = proc_rden_in && !rx_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign rx_push  = uart_rx_valid_in && (!rx_full || rx_pop);
  assign rx_drop  = uart_rx_valid_in && !rx_push;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_d;
      if (rx_drop) rx_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= uart_rx_data_in;
  end

  assign proc_data_out   = rx_mem_q[rx_rd_ptr_q];
  assign proc_valid_out  = !rx_empty;
  assign rx_overflow_out = rx_ovf_q;

  // TX FIFO: processor -> UART, drained by the FSM below
  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  logic          tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty       = (tx_cnt_q == '0);
  assign tx_full        = (tx_cnt_q == CNT_FULL);
  assign tx_push        = proc_wren_in && !tx_full;
  assign proc_ready_out = !tx_full;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= proc_data_in;
  end

  // TX drain FSM: the byte is latched on leaving IDLE and held until the next launch
  tx_state_e  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    state_d           = state_q;
    tx_data_d         = tx_data_q;
    tx_pop            = 1'b0;
    uart_tx_start_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty && !uart_tx_busy_in) begin
          state_d   = START;
          tx_data_d = tx_mem_q[tx_rd_ptr_q];
          tx_pop    = 1'b1;
        end
      end
      START: begin
        uart_tx_start_out = 1'b1;
        state_d           = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy_in) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign uart_tx_data_out = tx_data_q;

`ifdef SERIAL_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else if (rx_drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign rx_drop_count_out = drop_cnt_q;
`endif

endmodule
